// File: rtl/clkgen_drp_multi.sv
// rtl/clkgen_drp_multi.sv - DRP-programmable multi-output integer clock divider with lock gating
module clkgen_drp_multi #(
    parameter int NUM_OUT     = 6,
    parameter int CNT_WIDTH   = 8,
    parameter int DEF_DIVIDE  = 4,
    parameter int LOCK_CYCLES = 50
) (
    input  logic               CLKIN,
    input  logic               RST_N,
    input  logic               PWRDWN,
    input  logic [6:0]         DADDR,
    input  logic               DEN,
    input  logic               DWE,
    input  logic [15:0]        DI,
    output logic [15:0]        DO,
    output logic               DRDY,
    output logic               LOCKED,
    output logic [NUM_OUT-1:0] CLKOUT,
    output logic [NUM_OUT-1:0] CLKOUT_CE
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);
    localparam cnt_t TWO = cnt_t'(2);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_LOCK} state_t;

    state_t             state;
    logic [LW-1:0]      lock_cnt;
    cnt_t               divide_r [NUM_OUT];
    cnt_t               high_r   [NUM_OUT];
    cnt_t               phase_r  [NUM_OUT];
    cnt_t               pos      [NUM_OUT];
    cnt_t               d_eff    [NUM_OUT];
    cnt_t               h_eff    [NUM_OUT];
    cnt_t               p_eff    [NUM_OUT];
    cnt_t               preset   [NUM_OUT];
    cnt_t               next_pos [NUM_OUT];
    logic [NUM_OUT-1:0] ch_hit;
    logic [NUM_OUT-1:0] clk_next;
    logic               chan_wr;
    logic               locked_next;
    logic [15:0]        rdata;

    // Channel i occupies 0x08+4*i .. 0x0B+4*i, so DADDR[6:2] == i+2 selects it.
    always_comb begin
        ch_hit  = '0;
        chan_wr = 1'b0;
        rdata   = '0;
        if (DADDR == 7'h00) rdata[1:0] = {PWRDWN, LOCKED};
        for (int i = 0; i < NUM_OUT; i++) begin
            ch_hit[i] = (DADDR[6:2] == 5'(i + 2));
            if (ch_hit[i]) begin
                case (DADDR[1:0])
                    2'd0:    rdata[CNT_WIDTH-1:0] = divide_r[i];
                    2'd1:    rdata[CNT_WIDTH-1:0] = high_r[i];
                    2'd2:    rdata[CNT_WIDTH-1:0] = phase_r[i];
                    default: ;
                endcase
                if (DADDR[1:0] != 2'd3) chan_wr = DEN & DWE;
            end
        end
    end

    // Power-down and restarts dominate; a restart on the locking cycle keeps LOCKED low.
    always_comb begin
        if (PWRDWN || chan_wr || state == S_IDLE) locked_next = 1'b0;
        else if (state == S_COUNT)                locked_next = (lock_cnt == LOCK_LAST);
        else                                      locked_next = 1'b1;
    end

    // Counters sit at the phase preset until locked, so the first rise lands P cycles after lock.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            d_eff[i] = (divide_r[i] < TWO) ? TWO : divide_r[i];
            h_eff[i] = (high_r[i] == '0) ? ONE : high_r[i];
            if (h_eff[i] > d_eff[i] - ONE) h_eff[i] = d_eff[i] - ONE;
            p_eff[i]  = (phase_r[i] > d_eff[i] - ONE) ? d_eff[i] - ONE : phase_r[i];
            preset[i] = (p_eff[i] == '0) ? '0 : d_eff[i] - p_eff[i];
            if (LOCKED && locked_next)
                next_pos[i] = (pos[i] == d_eff[i] - ONE) ? '0 : pos[i] + ONE;
            else
                next_pos[i] = preset[i];
            clk_next[i] = locked_next && (next_pos[i] < h_eff[i]);
        end
    end

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_COUNT;
            lock_cnt <= '0;
            LOCKED   <= 1'b0;
        end else begin
            LOCKED <= locked_next;
            if (PWRDWN) begin
                state    <= S_IDLE;
                lock_cnt <= '0;
            end else if (chan_wr || state == S_IDLE) begin
                state    <= S_COUNT;
                lock_cnt <= '0;
            end else if (state == S_COUNT) begin
                if (lock_cnt == LOCK_LAST) state <= S_LOCK;
                else                       lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                divide_r[i] <= cnt_t'(DEF_DIVIDE);
                high_r[i]   <= cnt_t'(DEF_DIVIDE / 2);
                phase_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (DEN && DWE && ch_hit[i]) begin
                    case (DADDR[1:0])
                        2'd0:    divide_r[i] <= DI[CNT_WIDTH-1:0];
                        2'd1:    high_r[i]   <= DI[CNT_WIDTH-1:0];
                        2'd2:    phase_r[i]  <= DI[CNT_WIDTH-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            DO   <= '0;
            DRDY <= 1'b0;
        end else begin
            DRDY <= DEN;
            if (DEN) DO <= DWE ? 16'h0000 : rdata;
        end
    end

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_OUT; i++) pos[i] <= '0;
            CLKOUT    <= '0;
            CLKOUT_CE <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) pos[i] <= next_pos[i];
            CLKOUT    <= clk_next;
            CLKOUT_CE <= clk_next & ~CLKOUT;
        end
    end
endmodule

// File: tb/tb_clkgen_drp_multi.sv
// tb/tb_clkgen_drp_multi.sv - scoreboard testbench for clkgen_drp_multi
module tb_clkgen_drp_multi;
    logic        clk;
    logic        rst_n;
    logic        pwrdwn;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;
    logic        locked;
    logic [5:0]  clkout;
    logic [5:0]  clkout_ce;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];
    logic [1:0]  wave_q [$];

    clkgen_drp_multi #(
        .NUM_OUT(6), .CNT_WIDTH(8), .DEF_DIVIDE(4), .LOCK_CYCLES(50)
    ) u_dut (
        .CLKIN(clk), .RST_N(rst_n), .PWRDWN(pwrdwn), .DADDR(daddr), .DEN(den),
        .DWE(dwe), .DI(di), .DO(dout), .DRDY(drdy), .LOCKED(locked),
        .CLKOUT(clkout), .CLKOUT_CE(clkout_ce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drp_access(input logic [6:0] a, input logic we, input logic [15:0] d,
                              output logic rdy, output logic [15:0] q);
        daddr = a; dwe = we; di = d; den = 1'b1;
        tick;
        rdy = drdy; q = dout;
        den = 1'b0; dwe = 1'b0;
    endtask

    task automatic wait_lock(output int n);
        int i;
        i = 0; n = -1;
        while (n < 0 && i < 200) begin
            i++;
            tick;
            if (locked === 1'b1) n = i;
        end
    endtask

    // Called on the sample where LOCKED first reads 1 (k = 0).
    task automatic check_wave(input int ch, input int d, input int h, input int p, input int cycles);
        logic [1:0] e;
        for (int k = 0; k < cycles; k++) begin
            e[1] = (k >= p) && (((k - p) % d) < h);
            e[0] = (k >= p) && (((k - p) % d) == 0);
            wave_q.push_back(e);
        end
        for (int k = 0; k < cycles; k++) begin
            e = wave_q.pop_front();
            total++;
            if ({clkout[ch], clkout_ce[ch]} !== e) begin
                bad++;
                $display("FAIL wave ch%0d k=%0d got clk/ce=%b required=%b", ch, k, {clkout[ch], clkout_ce[ch]}, e);
            end
            if (k < cycles - 1) tick;
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0; pwrdwn = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
        tick; tick;
        total++;
        if ({locked, drdy, dout, clkout, clkout_ce} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs got locked=%b drdy=%b do=%h clkout=%b ce=%b required all 0",
                     locked, drdy, dout, clkout, clkout_ce);
        end
        rst_n = 1'b1;
        wait_lock(n);
        total++;
        if (n !== 50) begin bad++; $display("FAIL reset_lock_time got %0d required 50", n); end
        check_wave(0, 4, 2, 0, 12);
    endtask

    task automatic test_reconfig;
        logic rdy; logic [15:0] q; int n;
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL reconfig_pre_locked got %b required 1", locked); end
        drp_access(7'h0C, 1'b1, 16'd5, rdy, q);
        total++;
        if (locked !== 1'b0 || clkout !== 6'd0 || clkout_ce !== 6'd0) begin
            bad++;
            $display("FAIL reconfig_drop got locked=%b clkout=%b ce=%b required 0/0/0", locked, clkout, clkout_ce);
        end
        total++;
        if (rdy !== 1'b1 || q !== 16'h0000) begin
            bad++; $display("FAIL write_ack got drdy=%b do=%h required 1/0000", rdy, q);
        end
        drp_access(7'h0D, 1'b1, 16'd3, rdy, q);
        drp_access(7'h0E, 1'b1, 16'd2, rdy, q);
        wait_lock(n);
        total++;
        if (n !== 50) begin bad++; $display("FAIL reconfig_lock_time got %0d required 50", n); end
        check_wave(1, 5, 3, 2, 15);
    endtask

    task automatic test_clamp;
        logic rdy; logic [15:0] q; logic [15:0] e; int n;
        drp_access(7'h10, 1'b1, 16'd0, rdy, q);
        drp_access(7'h11, 1'b1, 16'd9, rdy, q);
        wait_lock(n);
        total++;
        if (n !== 50) begin bad++; $display("FAIL clamp_lock_time got %0d required 50", n); end
        check_wave(2, 2, 1, 0, 8);
        exp_q.push_back(16'h0000);
        drp_access(7'h10, 1'b0, 16'h0, rdy, q);
        e = exp_q.pop_front();
        total++;
        if (rdy !== 1'b1 || q !== e) begin bad++; $display("FAIL clamp_read_divide got drdy=%b do=%h required 1/%h", rdy, q, e); end
        exp_q.push_back(16'h0009);
        drp_access(7'h11, 1'b0, 16'h0, rdy, q);
        e = exp_q.pop_front();
        total++;
        if (rdy !== 1'b1 || q !== e) begin bad++; $display("FAIL clamp_read_high got drdy=%b do=%h required 1/%h", rdy, q, e); end
        tick;
        total++;
        if (drdy !== 1'b0 || dout !== 16'h0009) begin
            bad++; $display("FAIL do_hold got drdy=%b do=%h required 0/0009", drdy, dout);
        end
    endtask

    task automatic test_back_to_back;
        logic rdy; logic [15:0] q; logic [15:0] e;
        logic [6:0] addrs [3];
        addrs[0] = 7'h00; addrs[1] = 7'h08; addrs[2] = 7'h7F;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0004); exp_q.push_back(16'h0000);
        for (int i = 0; i < 3; i++) begin
            drp_access(addrs[i], 1'b0, 16'h0, rdy, q);
            e = exp_q.pop_front();
            total++;
            if (rdy !== 1'b1 || q !== e) begin
                bad++; $display("FAIL b2b_read%0d got drdy=%b do=%h required 1/%h", i, rdy, q, e);
            end
        end
        tick;
        total++;
        if (drdy !== 1'b0) begin bad++; $display("FAIL b2b_drdy_drop got %b required 0", drdy); end
        addrs[0] = 7'h00; addrs[1] = 7'h0B; addrs[2] = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            drp_access(addrs[i], 1'b1, 16'hFFFF, rdy, q);
            total++;
            if (rdy !== 1'b1 || q !== 16'h0000 || locked !== 1'b1) begin
                bad++; $display("FAIL ignored_write%0d got drdy=%b do=%h locked=%b required 1/0000/1", i, rdy, q, locked);
            end
        end
        exp_q.push_back(16'h0000);
        drp_access(7'h0B, 1'b0, 16'h0, rdy, q);
        e = exp_q.pop_front();
        total++;
        if (rdy !== 1'b1 || q !== e) begin bad++; $display("FAIL reserved_read got drdy=%b do=%h required 1/%h", rdy, q, e); end
    endtask

    task automatic test_pwrdwn;
        logic rdy; logic [15:0] q; logic [15:0] e; int n;
        pwrdwn = 1'b1;
        drp_access(7'h0C, 1'b1, 16'd6, rdy, q);
        total++;
        if (locked !== 1'b0 || clkout !== 6'd0) begin
            bad++; $display("FAIL pwrdwn_stop got locked=%b clkout=%b required 0/0", locked, clkout);
        end
        repeat (60) tick;
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL pwrdwn_hold got %b required 0", locked); end
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0006);
        drp_access(7'h00, 1'b0, 16'h0, rdy, q);
        e = exp_q.pop_front();
        total++;
        if (rdy !== 1'b1 || q !== e) begin bad++; $display("FAIL pwrdwn_status got drdy=%b do=%h required 1/%h", rdy, q, e); end
        drp_access(7'h0C, 1'b0, 16'h0, rdy, q);
        e = exp_q.pop_front();
        total++;
        if (rdy !== 1'b1 || q !== e) begin bad++; $display("FAIL pwrdwn_write_taken got drdy=%b do=%h required 1/%h", rdy, q, e); end
        pwrdwn = 1'b0;
        tick;
        wait_lock(n);
        total++;
        if (n !== 50) begin bad++; $display("FAIL pwrdwn_lock_time got %0d required 50", n); end
        check_wave(1, 6, 3, 2, 14);
    endtask

    task automatic test_async_reset;
        logic rdy; logic [15:0] q; logic [15:0] e; int n; int i;
        logic [6:0] addrs [3];
        i = 0;
        while (clkout[0] !== 1'b1 && i < 8) begin i++; tick; end
        total++;
        if (clkout[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_high got %b required 1", clkout[0]); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({locked, drdy, dout, clkout, clkout_ce} !== 30'd0) begin
            bad++;
            $display("FAIL async_reset got locked=%b drdy=%b do=%h clkout=%b ce=%b required all 0",
                     locked, drdy, dout, clkout, clkout_ce);
        end
        tick;
        rst_n = 1'b1;
        wait_lock(n);
        total++;
        if (n !== 50) begin bad++; $display("FAIL async_reset_lock_time got %0d required 50", n); end
        addrs[0] = 7'h0C; addrs[1] = 7'h0D; addrs[2] = 7'h0E;
        exp_q.push_back(16'h0004); exp_q.push_back(16'h0002); exp_q.push_back(16'h0000);
        for (int k = 0; k < 3; k++) begin
            drp_access(addrs[k], 1'b0, 16'h0, rdy, q);
            e = exp_q.pop_front();
            total++;
            if (rdy !== 1'b1 || q !== e) begin
                bad++; $display("FAIL default_reg%0d got drdy=%b do=%h required 1/%h", k, rdy, q, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_reconfig;
        test_clamp;
        test_back_to_back;
        test_pwrdwn;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
